// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory between the instruction-fetch (read-only) and data-cache (read/write) ports,
// serialising transactions through IDLE/ISSUE/WAIT/DONE and breaking ties round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  // grant/last: 0 = instruction side, 1 = data side
  logic grant_q, grant_d, last_q, last_d;
  logic m_read_q, m_read_d, m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic i_req, d_req, pick_d;
  assign i_req  = I_READ;
  assign d_req  = D_READ | D_WRITE;
  assign pick_d = d_req & (~i_req | ~last_q);
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (i_req | d_req) begin
        state_d   = ISSUE;
        grant_d   = pick_d;
        m_addr_d  = pick_d ? D_ADDRESS : I_ADDRESS;
        m_wdata_d = pick_d ? D_WRITEDATA : m_wdata_q;
        m_write_d = pick_d & D_WRITE;
        m_read_d  = ~(pick_d & D_WRITE);
      end
      ISSUE: state_d = WAIT;
      WAIT: if (!M_BUSYWAIT) begin
        state_d   = DONE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
        last_d    = grant_q;
        i_rdata_d = (m_read_q & ~grant_q) ? M_READDATA : i_rdata_q;
        d_rdata_d = (m_read_q & grant_q) ? M_READDATA : d_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign I_BUSYWAIT  = i_req & ~(state_q == DONE & ~grant_q);
  assign D_BUSYWAIT  = d_req & ~(state_q == DONE & grant_q);
  assign M_READ      = m_read_q;
  assign M_WRITE     = m_write_q;
  assign M_ADDRESS   = m_addr_q;
  assign M_WRITEDATA = m_wdata_q;
  assign I_READDATA  = i_rdata_q;
  assign D_READDATA  = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table of single transactions plus directed sequences for
// address change during WAIT, withdrawn request, mid-transaction reset and round-robin alternation.
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_READ, D_READ, D_WRITE;
  logic [5:0]  I_ADDRESS, D_ADDRESS, M_ADDRESS;
  logic [31:0] D_WRITEDATA, I_READDATA, D_READDATA, M_WRITEDATA, M_READDATA;
  logic        I_BUSYWAIT, D_BUSYWAIT, M_READ, M_WRITE, M_BUSYWAIT;
  int checks = 0;
  int fails = 0;
  mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
  );
  always #5 CLK = ~CLK;
  // memory model: busy for the first lat strobe cycles (the ISSUE cycle included)
  int          lat = 1;
  int          cnt = 0;
  logic [63:0] vld = '0;
  logic [31:0] mem [64];
  logic        overlap = 1'b0;
  assign M_BUSYWAIT = (M_READ | M_WRITE) && cnt < lat;
  assign M_READDATA = vld[M_ADDRESS] ? mem[M_ADDRESS] :
                      (M_ADDRESS == 6'h05 ? 32'hDEADBEEF : 32'hA5000000 | {26'd0, M_ADDRESS});
  always @(posedge CLK) begin
    cnt <= (M_READ | M_WRITE) ? cnt + 1 : 0;
    if (M_WRITE && !M_BUSYWAIT && cnt > 0) begin
      mem[M_ADDRESS] <= M_WRITEDATA;
      vld[M_ADDRESS] <= 1'b1;
    end
  end
  always @(negedge CLK) if (M_READ && M_WRITE) overlap <= 1'b1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic ir; logic [5:0] ia; logic dr; logic dw; logic [5:0] da; logic [31:0] dwd; int lt;
    logic es; logic [5:0] ea; logic erd; logic ewr; logic [31:0] eird; logic [31:0] edrd;
  } vec_t;
  vec_t vt [8];
  task automatic idle_inputs();
    I_READ = 0; D_READ = 0; D_WRITE = 0;
  endtask
  task automatic run_vec(input vec_t v);
    logic sbw, obw, oreq, done, other_ok;
    int n;
    I_READ = v.ir; I_ADDRESS = v.ia; D_READ = v.dr; D_WRITE = v.dw;
    D_ADDRESS = v.da; D_WRITEDATA = v.dwd; lat = v.lt;
    oreq = v.es ? v.ir : (v.dr | v.dw);
    @(posedge CLK); #1;
    chk("grant_addr", {26'd0, M_ADDRESS}, {26'd0, v.ea});
    chk("grant_mread", {31'd0, M_READ}, {31'd0, v.erd});
    chk("grant_mwrite", {31'd0, M_WRITE}, {31'd0, v.ewr});
    if (v.ewr) chk("grant_wdata", M_WRITEDATA, v.dwd);
    n = 0; done = 0; other_ok = 1;
    for (int k = 0; k < 40; k++) begin
      sbw = v.es ? D_BUSYWAIT : I_BUSYWAIT;
      obw = v.es ? I_BUSYWAIT : D_BUSYWAIT;
      if (obw !== oreq) other_ok = 0;
      if (!sbw) begin
        done = 1;
        break;
      end
      n += int'(M_READ | M_WRITE);
      @(posedge CLK); #1;
    end
    chk("completed", {31'd0, done}, 32'd1);
    chk("strobe_cycles", n, v.lt + 1);
    chk("other_busywait", {31'd0, other_ok}, 32'd1);
    chk("i_readdata", I_READDATA, v.eird);
    chk("d_readdata", D_READDATA, v.edrd);
    @(posedge CLK); #1;
    chk("busywait_low_once", {31'd0, v.es ? D_BUSYWAIT : I_BUSYWAIT}, 32'd1);
    idle_inputs();
  endtask
  initial begin
    logic addr_ok, both_low, got_it;
    logic seq [4];
    int got;
    RESET = 1; idle_inputs(); I_ADDRESS = 0; D_ADDRESS = 0; D_WRITEDATA = 0;
    vt[0] = '{1, 6'h05, 0, 0, 6'h00, 32'h0,        4, 0, 6'h05, 1, 0, 32'hDEADBEEF, 32'h0};
    vt[1] = '{0, 6'h00, 0, 1, 6'h2A, 32'h12345678, 2, 1, 6'h2A, 0, 1, 32'hDEADBEEF, 32'h0};
    vt[2] = '{0, 6'h00, 1, 0, 6'h10, 32'h0,        1, 1, 6'h10, 1, 0, 32'hDEADBEEF, 32'hA5000010};
    vt[3] = '{0, 6'h00, 1, 0, 6'h2A, 32'h0,        1, 1, 6'h2A, 1, 0, 32'hDEADBEEF, 32'h12345678};
    vt[4] = '{0, 6'h00, 1, 1, 6'h07, 32'hCAFEF00D, 2, 1, 6'h07, 0, 1, 32'hDEADBEEF, 32'h12345678};
    vt[5] = '{1, 6'h07, 0, 0, 6'h00, 32'h0,        3, 0, 6'h07, 1, 0, 32'hCAFEF00D, 32'h12345678};
    vt[6] = '{1, 6'h2A, 1, 0, 6'h05, 32'h0,        1, 1, 6'h05, 1, 0, 32'hCAFEF00D, 32'hDEADBEEF};
    vt[7] = '{1, 6'h2A, 1, 0, 6'h10, 32'h0,        2, 0, 6'h2A, 1, 0, 32'h12345678, 32'hDEADBEEF};
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 0;
    chk("rst_mread", {31'd0, M_READ}, 32'd0);
    chk("rst_mwrite", {31'd0, M_WRITE}, 32'd0);
    chk("rst_maddr", {26'd0, M_ADDRESS}, 32'd0);
    chk("rst_mwdata", M_WRITEDATA, 32'd0);
    chk("rst_irdata", I_READDATA, 32'd0);
    chk("rst_drdata", D_READDATA, 32'd0);
    chk("rst_ibw", {31'd0, I_BUSYWAIT}, 32'd0);
    chk("rst_dbw", {31'd0, D_BUSYWAIT}, 32'd0);
    for (int i = 0; i < 8; i++) run_vec(vt[i]);
    // address change during WAIT, then a read withdrawn during WAIT
    D_READ = 1; D_ADDRESS = 6'h01; lat = 3;
    @(posedge CLK); #1;
    chk("addr_hold_issue", {26'd0, M_ADDRESS}, 32'h01);
    @(posedge CLK); #1;
    D_ADDRESS = 6'h3F;
    addr_ok = 1; got_it = 0;
    for (int k = 0; k < 40; k++) begin
      if (!D_BUSYWAIT) begin
        got_it = 1;
        break;
      end
      if (M_ADDRESS !== 6'h01) addr_ok = 0;
      @(posedge CLK); #1;
    end
    chk("addr_change_done", {31'd0, got_it}, 32'd1);
    chk("addr_hold_wait", {31'd0, addr_ok}, 32'd1);
    chk("addr_hold_rdata", D_READDATA, 32'hA5000001);
    lat = 2;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("next_grant_addr", {26'd0, M_ADDRESS}, 32'h3F);
    chk("next_grant_mread", {31'd0, M_READ}, 32'd1);
    D_READ = 0;
    got_it = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (!M_READ) begin
        got_it = 1;
        break;
      end
    end
    chk("withdrawn_done", {31'd0, got_it}, 32'd1);
    chk("withdrawn_rdata", D_READDATA, 32'hA500003F);
    @(posedge CLK); #1;
    // reset in the middle of WAIT
    I_READ = 1; I_ADDRESS = 6'h10; lat = 6;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2 RESET = 1;
    #1;
    chk("midrst_mread", {31'd0, M_READ}, 32'd0);
    chk("midrst_mwrite", {31'd0, M_WRITE}, 32'd0);
    chk("midrst_maddr", {26'd0, M_ADDRESS}, 32'd0);
    chk("midrst_irdata", I_READDATA, 32'd0);
    chk("midrst_drdata", D_READDATA, 32'd0);
    chk("midrst_ibw", {31'd0, I_BUSYWAIT}, 32'd1);
    D_READ = 1; D_ADDRESS = 6'h2A; lat = 1;
    @(posedge CLK); #1;
    RESET = 0;
    @(posedge CLK); #1;
    chk("first_conflict_addr", {26'd0, M_ADDRESS}, 32'h10);
    chk("first_conflict_mread", {31'd0, M_READ}, 32'd1);
    // both held: four transactions must alternate I, D, I, D
    got = 0; both_low = 0;
    for (int k = 0; k < 100 && got < 4; k++) begin
      if (!I_BUSYWAIT && !D_BUSYWAIT) both_low = 1;
      if (!I_BUSYWAIT) begin
        seq[got] = 0; got++;
      end else if (!D_BUSYWAIT) begin
        seq[got] = 1; got++;
      end
      @(posedge CLK); #1;
    end
    idle_inputs();
    chk("rr_count", got, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), {31'd0, seq[i]}, i % 2);
    chk("rr_loser_stalled", {31'd0, both_low}, 32'd0);
    chk("rr_irdata", I_READDATA, 32'hA5000010);
    chk("rr_drdata", D_READDATA, 32'h12345678);
    @(posedge CLK); #1;
    chk("strobe_overlap", {31'd0, overlap}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single block-organised data memory (32-bit blocks, 6-bit block address) between two requesters: the instruction-fetch port (read-only) and the data-cache port (read/write).
- Sits between the caches and the data memory module.
- Sequences each memory transaction through an FSM, stalls the losing requester via its BUSYWAIT, and resolves simultaneous requests round-robin.

Parameters:
- ADDR_W, 6, block address width.
- DATA_W, 32, block data width.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- I_READ  in  1  instruction-side read request.
- I_ADDRESS  in  ADDR_W  instruction-side block address.
- I_READDATA  out  DATA_W  instruction-side returned block (registered).
- I_BUSYWAIT  out  1  instruction-side stall.
- D_READ  in  1  data-side read request.
- D_WRITE  in  1  data-side write request.
- D_ADDRESS  in  ADDR_W  data-side block address.
- D_WRITEDATA  in  DATA_W  data-side write block.
- D_READDATA  out  DATA_W  data-side returned block (registered).
- D_BUSYWAIT  out  1  data-side stall.
- M_READ  out  1  memory read strobe (registered).
- M_WRITE  out  1  memory write strobe (registered).
- M_ADDRESS  out  ADDR_W  memory block address (registered).
- M_WRITEDATA  out  DATA_W  memory write block (registered).
- M_READDATA  in  DATA_W  memory read block.
- M_BUSYWAIT  in  1  memory busy.

Behaviour:
- Requests: I_REQ = I_READ; D_REQ = D_READ | D_WRITE. D_READ and D_WRITE together is illegal; it is treated as a write.
- Registered state: FSM state, GRANT (I or D), LAST (last side served).
- States:
  - IDLE: no request → stay. One request → grant it. Both → grant the side not equal to LAST.
  - On grant: at that posedge, latch M_ADDRESS, M_WRITEDATA, M_READ/M_WRITE from the granted port; go to ISSUE.
  - ISSUE: lasts exactly 1 cycle; M_BUSYWAIT is ignored; go to WAIT.
  - WAIT: at the posedge sampling M_BUSYWAIT==0:
    - on a read, capture M_READDATA into the granted X_READDATA;
    - clear M_READ/M_WRITE;
    - set LAST=GRANT;
    - go to DONE.
  - DONE: lasts 1 cycle; strobes low; go to IDLE. The next grant is evaluated in IDLE, so memory always sees at least one idle cycle between transactions.
- Requester stalls (combinational): X_BUSYWAIT = X_REQ & ~(state==DONE & GRANT==X). A requester sees BUSYWAIT low for exactly one cycle per completed transaction.
- Strobes: M_READ and M_WRITE are never high together. Both are low in IDLE and DONE.
- Request sampling: requester inputs are sampled only at grant. Changes to address or data during ISSUE/WAIT are ignored.
- Requests withdrawn in WAIT: the transaction still completes, and readdata is still captured.
- X_READDATA holds its value until that port's next read completes. Writes leave D_READDATA unchanged.
- Latency: a single uncontended read with a memory busy for N cycles in WAIT takes N+3 cycles from request to BUSYWAIT low.
- Reset (any time, including mid-transaction):
  - state=IDLE, GRANT=I, LAST=D;
  - M_READ=M_WRITE=0, M_ADDRESS=0, M_WRITEDATA=0;
  - I_READDATA=D_READDATA=0.
  - BUSYWAITs follow the combinational rule (high if a request is present).
  - On the first conflict after reset, the instruction side wins.

Test Plan:
- Reset: assert RESET mid-WAIT → M_READ=M_WRITE=0 immediately, state IDLE, both READDATA=0. Release with both requesting → instruction granted first.
- Lone instruction read: I_ADDRESS=6'h05, memory returns 32'hDEADBEEF after 4 busy cycles → M_READ high 5 cycles, I_READDATA=32'hDEADBEEF, I_BUSYWAIT low exactly 1 cycle, D outputs untouched.
- Lone data write: D_ADDRESS=6'h2A, D_WRITEDATA=32'h12345678 → M_WRITE with those values, M_READ=0 throughout, D_READDATA unchanged.
- Simultaneous requests, held 4 transactions: grants alternate I, D, I, D. The waiting side's BUSYWAIT stays high throughout the other's transaction.
- Address change during WAIT (D_ADDRESS 6'h01→6'h3F) → M_ADDRESS stays 6'h01 until DONE. The next grant uses 6'h3F.
- Illegal D_READ=D_WRITE=1 → M_WRITE only. Throughout all tests, an assertion checks that M_READ&M_WRITE is never 1.
